// File: rtl/pwm_drive_gen.sv
// Soft-start PWM generator for the H-bridge stage: prescaled 8-bit phase, per-period
// duty slew limiter, synchronised over-current cut-off and a sticky fault latch.
module pwm_drive_gen #(
    parameter int PRESCALE  = 390,
    parameter int RAMP_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] duty_sw,
    input  logic       oc_in,
    output logic       pulse,
    output logic       period_start,
    output logic [7:0] duty_active,
    output logic       fault
);

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [8:0]    STEP9    = 9'(RAMP_STEP);

    logic [PW-1:0] r_prescale;
    logic [7:0]    r_phase;
    logic [7:0]    r_duty;
    logic          r_fault;
    logic          r_pulse;
    logic          r_period_start;
    logic          r_oc_meta;
    logic          r_oc_sync;

    logic          w_tick;
    logic          w_wrap;
    logic          w_pulse_next;
    logic [8:0]    w_duty9;
    logic [8:0]    w_sw9;
    logic [8:0]    w_up;
    logic [7:0]    w_duty_ramp;

    assign w_tick = (r_prescale == PRE_LAST);
    assign w_wrap = w_tick && (r_phase == 8'hFF);

    // Slew-limited next duty; 9-bit compares keep the step from wrapping past 0 or 255.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_duty9     = {1'b0, r_duty};
        w_sw9       = {1'b0, duty_sw};
        w_up        = w_duty9 + STEP9;
        w_duty_ramp = r_duty;
        if (w_sw9 > w_duty9) begin
            w_duty_ramp = (w_up >= w_sw9) ? duty_sw : w_up[7:0];
        end else if (w_sw9 < w_duty9) begin
            w_duty_ramp = (w_duty9 <= w_sw9 + STEP9) ? duty_sw : (r_duty - STEP9[7:0]);
        end
    end

    assign w_pulse_next = enable && !r_fault && !r_oc_sync &&
                          ((r_duty == 8'hFF) || (r_phase < r_duty));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale     <= '0;
            r_phase        <= '0;
            r_duty         <= '0;
            r_fault        <= 1'b0;
            r_pulse        <= 1'b0;
            r_period_start <= 1'b0;
            r_oc_meta      <= 1'b0;
            r_oc_sync      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            r_oc_meta      <= oc_in;
            r_oc_sync      <= r_oc_meta;
            r_prescale     <= w_tick ? '0 : r_prescale + 1'b1;
            if (w_tick) begin
                r_phase <= r_phase + 8'd1;
            end
            r_period_start <= w_wrap;

            // Disable forces the applied duty to 0 so a re-enable always soft-starts.
            if (!enable) begin
                r_duty <= '0;
            end else if (w_wrap) begin
                r_duty <= w_duty_ramp;
            end

            if (!enable) begin
                r_fault <= 1'b0;
            end else if (r_oc_sync) begin
                r_fault <= 1'b1;
            end

            r_pulse <= w_pulse_next;
        end
    end

    assign pulse        = r_pulse;
    assign period_start = r_period_start;
    assign duty_active  = r_duty;
    assign fault        = r_fault;

endmodule
